// File: rtl/ksa_pipe_adder.sv
// Pipelined Kogge-Stone add/subtract unit.
// Stage 0 forms bitwise generate/propagate, stages 1..S each evaluate up to
// LVL_PER_STG prefix levels, and a final output stage forms the sum and the
// carry/overflow/zero flags. A single global stall (head result presented
// but not taken) freezes every register, so results and tags stay in order
// and a presented result never changes until it is consumed.
module ksa_pipe_adder #(
    parameter int WIDTH       = 32,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_ovf,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    // Number of Kogge-Stone levels; a 1-bit adder still gets one (trivial) level.
    localparam int LVLS = (WIDTH <= 1) ? 1 : $clog2(WIDTH);
    // Number of prefix pipeline stages; the last one takes the remainder.
    localparam int S    = (LVLS + LVL_PER_STG - 1) / LVL_PER_STG;

    // ------------------------------------------------------------------
    // Prefix helpers. Level j combines each bit with the bit 2^j below it.
    // Bits below the span keep their values, which the shifts give for free
    // (zeros shifted into g, ones masked into p).
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] span_g(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        g = g_in;
        p = p_in;
        for (int j = 0; j < LVLS; j++) begin
            if (j >= lo && j < hi) begin
                g = g | (p & (g << (1 << j)));
                p = p & ((p << (1 << j)) | ~({WIDTH{1'b1}} << (1 << j)));
            end
        end
        return g;
    endfunction

    function automatic logic [WIDTH-1:0] span_p(
        input logic [WIDTH-1:0] p_in,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] p;
        p = p_in;
        for (int j = 0; j < LVLS; j++) begin
            if (j >= lo && j < hi) begin
                p = p & ((p << (1 << j)) | ~({WIDTH{1'b1}} << (1 << j)));
            end
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Flow control: everything advances unless the head result is stalled.
    // ------------------------------------------------------------------
    logic en;
    assign en      = !(o_valid && !o_ready);
    assign i_ready = en;

    // ------------------------------------------------------------------
    // Stage 0 front end: operand conditioning and bitwise G/P.
    // The carry-in is folded into bit 0's generate so that the final prefix
    // generate of bit i is directly the carry out of bit i.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] g0;
    logic [WIDTH-1:0] p0;
    logic             cin0;

    // Condition B for subtract and form per-bit generate/propagate.
    always_comb begin
        // NOTE: every variable gets a full assignment before any partial
        // update, so no path through the block can leave a latch behind.
        b_eff = i_sub ? ~i_b : i_b;
        cin0  = i_sub ? 1'b1 : i_carry;
        p0    = i_a ^ b_eff;
        g0    = i_a & b_eff;
        g0[0] = g0[0] | (p0[0] & cin0);
    end

    // ------------------------------------------------------------------
    // Pipeline state. Index 0 is the stage-0 register, index S the final
    // prefix register. Propagate is not needed after the last prefix stage,
    // so it is only carried through stages 0..S-1.
    // ------------------------------------------------------------------
    logic [S:0]                  v_q;
    logic [S:0][WIDTH-1:0]       g_q;
    logic [S:0][WIDTH-1:0]       g_d;
    logic [S-1:0][WIDTH-1:0]     p_q;
    logic [S-1:0][WIDTH-1:0]     p_d;
    logic [S:0][WIDTH-1:0]       x_q;     // half-sum a ^ b', needed for the final xor
    logic [S:0]                  am_q;    // A[MSB] for the overflow flag
    logic [S:0]                  bm_q;    // B'[MSB] for the overflow flag
    logic [S:0]                  ci_q;    // effective carry-in (carry into bit 0)
    logic [S:0][TAG_W-1:0]       tag_q;

    assign g_d[0] = g0;
    assign p_d[0] = p0;

    // Each prefix stage evaluates its share of levels on the previous register.
    for (genvar k = 1; k <= S; k++) begin : g_stage
        localparam int LO = (k - 1) * LVL_PER_STG;
        localparam int HI = (k * LVL_PER_STG < LVLS) ? k * LVL_PER_STG : LVLS;

        assign g_d[k] = span_g(g_q[k-1], p_q[k-1], LO, HI);

        if (k < S) begin : g_prop
            assign p_d[k] = span_p(p_q[k-1], LO, HI);
        end
    end

    // Advance the whole prefix pipeline together whenever the unit is not stalled.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every stage
        // samples the values the previous stage held before this edge.
        if (rst) begin
            // NOTE: the datapath registers are cleared along with the valid
            // bits so the outputs read all-zero while reset is held.
            v_q   <= '0;
            g_q   <= '0;
            p_q   <= '0;
            x_q   <= '0;
            am_q  <= '0;
            bm_q  <= '0;
            ci_q  <= '0;
            tag_q <= '0;
        end else if (en) begin
            v_q   <= {v_q[S-1:0], i_valid};
            g_q   <= g_d;
            p_q   <= p_d;
            x_q   <= {x_q[S-1:0], p0};
            am_q  <= {am_q[S-1:0], i_a[WIDTH-1]};
            bm_q  <= {bm_q[S-1:0], b_eff[WIDTH-1]};
            ci_q  <= {ci_q[S-1:0], cin0};
            tag_q <= {tag_q[S-1:0], i_tag};
        end
    end

    // ------------------------------------------------------------------
    // Output stage: sum and flags from the final prefix register.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   carry_vec;   // carry into each bit, plus carry out at the top
    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;

    // Form the sum from carries-in and the saved half-sum, then derive flags.
    always_comb begin
        carry_vec = {g_q[S], ci_q[S]};
        sum_d     = x_q[S] ^ carry_vec[WIDTH-1:0];
        carry_d   = carry_vec[WIDTH];
        ovf_d     = (am_q[S] == bm_q[S]) && (sum_d[WIDTH-1] != am_q[S]);
        zero_d    = ~|sum_d;
    end

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic [TAG_W-1:0] otag_q;

    // Register the result; it holds while the downstream is not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            otag_q  <= '0;
        end else if (en) begin
            valid_q <= v_q[S];
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            otag_q  <= tag_q[S];
        end
    end

    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_carry = carry_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;
    assign o_tag   = otag_q;

endmodule

// File: doc/ksa_pipe_adder.md
Name: ksa_pipe_adder

Overview:
- Pipelined, parametrised Kogge-Stone add/subtract unit with a valid/ready handshake on both sides and sideband tag passthrough.
- Successor to the combinational KSA. Adds configurable register insertion between prefix levels, a subtract mode, and status flags (carry, signed overflow, zero).
- Serves as the modular-add primitive in the SHA-256 round datapath (WIDTH=32) and closes timing at higher clock rates than the flat adder.

Parameters:
- WIDTH, 32, operand/sum width in bits (>=1).
- LVL_PER_STG, 2, prefix levels evaluated between pipeline registers (>=1).
- TAG_W, 4, width of sideband tag carried alongside each operation (>=1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input operation valid.
- i_ready  out  1  unit accepts input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_carry  in  1  carry-in (ignored when i_sub=1).
- i_sub  in  1  0: A+B+i_carry; 1: A-B (A + ~B + 1).
- i_tag  in  TAG_W  sideband tag.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_sum  out  WIDTH  result mod 2^WIDTH.
- o_carry  out  1  carry-out of MSB (for subtract: 1 = no borrow).
- o_ovf  out  1  two's-complement signed overflow.
- o_zero  out  1  o_sum == 0.
- o_tag  out  TAG_W  tag of this result.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, all pipeline valid bits and all outputs (o_valid, o_sum, o_carry, o_ovf, o_zero, o_tag) are 0. i_ready follows its equation below.
- Level count: L = max(1, ceil(log2(WIDTH))). Prefix stage count: S = ceil(L / LVL_PER_STG).
- Pipeline structure:
  - Stage 0 forms B' = i_sub ? ~i_b : i_b and cin = i_sub ? 1 : i_carry. It forms bitwise G/P and registers them together with A[MSB], B'[MSB], cin and the tag.
  - Stages 1..S each evaluate LVL_PER_STG Kogge-Stone levels (the last stage takes the remainder) and register the result.
  - The sum, carry and flags are computed from the final prefix register and registered into the output stage.
- Latency: LAT = S + 2 cycles from an accepted input (i_valid && i_ready at edge k) to o_valid=1 after edge k+LAT-1, provided there is no stall. For WIDTH=32 and LVL_PER_STG=2: L=5, S=3, LAT=5.
- Throughput: one operation per cycle when o_ready=1.
- Flow control uses a global stall: en = !(o_valid && !o_ready).
  - i_ready = en.
  - When en=0, every pipeline register holds and the outputs stay stable. A presented result never changes until it is consumed.
  - Bubbles are not collapsed. Input blocks while the head result is stalled, even if internal stages are empty.
- Valid bits propagate per stage. A stage with valid=0 still clocks its data when en=1; its contents are don't-care.
- Flag definitions:
  - o_carry is the carry out of bit WIDTH-1.
  - o_ovf = (A[MSB] == B'[MSB]) && (o_sum[MSB] != A[MSB]).
  - o_zero = ~|o_sum.
  - Flags are valid only with o_valid.
- Arithmetic: all results wrap mod 2^WIDTH. With WIDTH=1 the unit reduces to a full adder with L=1.
- An input presented while i_ready=0 is not accepted. The source must hold it; the unit samples nothing.
- Reset mid-operation flushes all in-flight operations. No result is emitted for them, and o_valid is 0 in the first cycle after rst deasserts.
- Tags are returned in order, unmodified, paired with their own result.

Test Plan:
- WIDTH=8, LVL_PER_STG=1, o_ready=1: exhaustive a,b in 0..255 × i_carry in {0,1}, add mode, streamed back-to-back -> every {o_carry,o_sum} equals a+b+cin, one result per cycle after LAT=5 cycles, tags match in order, zero mismatches.
- WIDTH=32 edge sums: 0xFFFFFFFF+0x00000001 -> o_sum=0, o_carry=1, o_zero=1, o_ovf=0. 0x7FFFFFFF+0x00000001 -> 0x80000000, o_ovf=1, o_carry=0.
- WIDTH=32 subtract: 5-7 -> o_sum=0xFFFFFFFE, o_carry=0. 7-5 -> 0x00000002, o_carry=1. 0x80000000-1 -> 0x7FFFFFFF, o_ovf=1.
- Backpressure: stream 20 random ops, hold o_ready=0 for 6 cycles mid-stream -> i_ready=0 during the stall, o_sum/o_tag stable, no result lost or duplicated, order preserved.
- Reset mid-flight: issue 3 ops, assert rst asynchronously between clock edges 2 cycles later -> outputs go to 0 immediately, no stale results after release, and the next op returns after exactly LAT cycles.
- Parameter sweep WIDTH ∈ {1,5,32,64} × LVL_PER_STG ∈ {1,2,3}: random add/sub traffic -> latency equals S+2 and results match the golden A±B model.
